// File: rtl/led7_pkg.sv
// -----------------------------------------------------------------------------
// led7_pkg
// Shared constants for the multiplexed 7-segment LED path. The display
// driver's encoder and the capture-side decoder use the same patterns, so
// encode and decode always agree.
// Segment patterns are ordered {a,b,c,d,e,f,g}, MSB = a, 1 = segment lit.
// -----------------------------------------------------------------------------
package led7_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;

    localparam logic [3:0] BCD_INVALID = 4'hF;

    // Index of the set bit of a one-hot digit strobe. Callers qualify the
    // strobe with $onehot first; for other inputs the result is unused.
    function automatic logic [2:0] onehot_to_idx(input logic [NUM_DIGITS-1:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/led7_seg_decode.sv
// -----------------------------------------------------------------------------
// led7_seg_decode
// Combinational segment-pattern to BCD decoder.
// Ports:
//   seg   in  7  {a,b,c,d,e,f,g}, 1 = lit
//   valid out 1  pattern is one of the ten digit glyphs
//   bcd   out 4  decoded digit, BCD_INVALID when the pattern is unknown
// -----------------------------------------------------------------------------
module led7_seg_decode
    import led7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] bcd
);

    always_comb begin
        valid = 1'b1;
        bcd   = BCD_INVALID;
        case (seg)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/led_display_capture.sv
// -----------------------------------------------------------------------------
// led_display_capture
// Receive side of the multiplexed 7-segment LED interface. Samples the
// segment and digit-enable lines, waits for each strobe to settle, decodes
// the digit back to BCD and reassembles 6-digit frames. A frame is published
// when the scan wraps to a lower digit index, or after a long idle period
// when a partial frame is pending.
// Ports:
//   clk                 in   1   system clock
//   reset               in   1   synchronous, active-high
//   led_segments        in   8   async; [7:1] = a..g, [0] = dp; 1 = lit
//   led_enable_mask     in   6   async; one-hot digit strobe
//   frame_data          out 24   digit i BCD in [4i+3:4i]
//   frame_present_mask  out  6   digit i present in published frame
//   frame_decode_error  out  1   a captured digit had an unknown pattern
//   frame_valid         out  1   one-cycle pulse when frame_* update
// -----------------------------------------------------------------------------
module led_display_capture
    import led7_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              led_segments,
    input  logic [NUM_DIGITS-1:0]   led_enable_mask,
    output logic [4*NUM_DIGITS-1:0] frame_data,
    output logic [NUM_DIGITS-1:0]   frame_present_mask,
    output logic                    frame_decode_error,
    output logic                    frame_valid
);

    localparam int         TO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0] SETTLE_MAX = 4'(SETTLE_CYCLES);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    // Two-flop synchronisers plus the previous synced sample for settling.
    logic [7:0]            seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, seg_prev_q, seg_prev_d;
    logic [NUM_DIGITS-1:0] en_s1_q, en_s1_d, en_s2_q, en_s2_d, en_prev_q, en_prev_d;

    logic [3:0]            settle_q, settle_d;
    logic [TO_W-1:0]       to_q, to_d;

    logic [4*NUM_DIGITS-1:0] acc_data_q, acc_data_d;
    logic [NUM_DIGITS-1:0]   acc_mask_q, acc_mask_d;
    logic                    acc_err_q, acc_err_d;
    logic [2:0]              last_idx_q, last_idx_d;

    logic [4*NUM_DIGITS-1:0] frame_data_q, frame_data_d;
    logic [NUM_DIGITS-1:0]   frame_mask_q, frame_mask_d;
    logic                    frame_err_q, frame_err_d;
    logic                    frame_valid_q, frame_valid_d;

    logic       same, capture, wrap, timeout;
    logic [2:0] cap_idx;
    logic       dec_valid;
    logic [3:0] dec_bcd;

    led7_seg_decode u_dec (
        .seg   (seg_s2_q[7:1]),
        .valid (dec_valid),
        .bcd   (dec_bcd)
    );

    always_comb begin
        seg_s1_d   = led_segments;
        seg_s2_d   = seg_s1_q;
        seg_prev_d = seg_s2_q;
        en_s1_d    = led_enable_mask;
        en_s2_d    = en_s1_q;
        en_prev_d  = en_s2_q;

        // dp takes part in the stability check, so a dp change starts a new
        // stable run and re-captures the (unchanged) digit value.
        same = ({seg_s2_q, en_s2_q} == {seg_prev_q, en_prev_q});

        settle_d = settle_q;
        if (!same)                     settle_d = 4'd0;
        else if (settle_q != SETTLE_MAX) settle_d = settle_q + 4'd1;

        // Fires only on the transition into SETTLE_MAX, once per stable run.
        capture = same && (settle_q == SETTLE_MAX - 4'd1) && $onehot(en_s2_q);
        cap_idx = onehot_to_idx(en_s2_q);
        wrap    = capture && (cap_idx < last_idx_q) && (acc_mask_q != '0);
        timeout = !capture && (to_q == TO_MAX) && (acc_mask_q != '0);

        acc_data_d    = acc_data_q;
        acc_mask_d    = acc_mask_q;
        acc_err_d     = acc_err_q;
        last_idx_d    = last_idx_q;
        frame_data_d  = frame_data_q;
        frame_mask_d  = frame_mask_q;
        frame_err_d   = frame_err_q;
        frame_valid_d = 1'b0;

        to_d = to_q;
        if (capture || timeout)  to_d = '0;
        else if (to_q != TO_MAX) to_d = to_q + 1'b1;

        if (wrap || timeout) begin
            frame_data_d  = acc_data_q;
            frame_mask_d  = acc_mask_q;
            frame_err_d   = acc_err_q;
            frame_valid_d = 1'b1;
            acc_data_d    = '0;
            acc_mask_d    = '0;
            acc_err_d     = 1'b0;
        end

        // On a wrap this lands in the freshly cleared accumulator, so the
        // new frame starts holding only the wrapping digit.
        if (capture) begin
            acc_data_d[{cap_idx, 2'b00} +: 4] = dec_bcd;
            acc_mask_d[cap_idx] = 1'b1;
            if (!dec_valid) acc_err_d = 1'b1;
            last_idx_d = cap_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_s1_q      <= '0;
            seg_s2_q      <= '0;
            seg_prev_q    <= '0;
            en_s1_q       <= '0;
            en_s2_q       <= '0;
            en_prev_q     <= '0;
            settle_q      <= '0;
            to_q          <= '0;
            acc_data_q    <= '0;
            acc_mask_q    <= '0;
            acc_err_q     <= 1'b0;
            last_idx_q    <= '0;
            frame_data_q  <= '0;
            frame_mask_q  <= '0;
            frame_err_q   <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            seg_s1_q      <= seg_s1_d;
            seg_s2_q      <= seg_s2_d;
            seg_prev_q    <= seg_prev_d;
            en_s1_q       <= en_s1_d;
            en_s2_q       <= en_s2_d;
            en_prev_q     <= en_prev_d;
            settle_q      <= settle_d;
            to_q          <= to_d;
            acc_data_q    <= acc_data_d;
            acc_mask_q    <= acc_mask_d;
            acc_err_q     <= acc_err_d;
            last_idx_q    <= last_idx_d;
            frame_data_q  <= frame_data_d;
            frame_mask_q  <= frame_mask_d;
            frame_err_q   <= frame_err_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign frame_data         = frame_data_q;
    assign frame_present_mask = frame_mask_q;
    assign frame_decode_error = frame_err_q;
    assign frame_valid        = frame_valid_q;

endmodule

// File: tb/tb_led_display_capture.sv
module tb_led_display_capture;

    localparam int TIMEOUT = 16384;

    localparam logic [6:0] P0 = 7'b1111110;
    localparam logic [6:0] P1 = 7'b0110000;
    localparam logic [6:0] P2 = 7'b1101101;
    localparam logic [6:0] P3 = 7'b1111001;
    localparam logic [6:0] P4 = 7'b0110011;
    localparam logic [6:0] P5 = 7'b1011011;
    localparam logic [6:0] P6 = 7'b1011111;
    localparam logic [6:0] P7 = 7'b1110000;
    localparam logic [6:0] P8 = 7'b1111111;
    localparam logic [6:0] P9 = 7'b1111011;
    localparam logic [6:0] PBAD = 7'b0000001;

    logic        clk;
    logic        reset;
    logic [7:0]  led_segments;
    logic [5:0]  led_enable_mask;
    logic [23:0] frame_data;
    logic [5:0]  frame_present_mask;
    logic        frame_decode_error;
    logic        frame_valid;

    typedef struct {
        logic [23:0] d;
        logic [5:0]  m;
        logic        e;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   pulses = 0;
    int   snap;

    led_display_capture #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk                (clk),
        .reset              (reset),
        .led_segments       (led_segments),
        .led_enable_mask    (led_enable_mask),
        .frame_data         (frame_data),
        .frame_present_mask (frame_present_mask),
        .frame_decode_error (frame_decode_error),
        .frame_valid        (frame_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT pulses frame_valid.
    always @(negedge clk) begin
        if (frame_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_frame: actual data=%h mask=%h err=%b required no pulse",
                         frame_data, frame_present_mask, frame_decode_error);
            end else begin
                mon_e = exp_q.pop_front();
                chk("frame_data", 32'(frame_data), 32'(mon_e.d));
                chk("frame_mask", 32'(frame_present_mask), 32'(mon_e.m));
                chk("frame_err",  32'(frame_decode_error), 32'(mon_e.e));
            end
        end
    end

    task automatic push(input logic [23:0] d, input logic [5:0] m, input logic e);
        exp_t x;
        x.d = d; x.m = m; x.e = e;
        exp_q.push_back(x);
    endtask

    task automatic show(input int idx, input logic [6:0] pat, input logic dp, input int cyc);
        @(negedge clk);
        led_enable_mask = 6'(1 << idx);
        led_segments    = {pat, dp};
        repeat (cyc - 1) @(negedge clk);
    endtask

    task automatic idle(input int cyc);
        @(negedge clk);
        led_enable_mask = 6'h00;
        led_segments    = 8'h00;
        repeat (cyc - 1) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset           = 1'b1;
        led_enable_mask = 6'h00;
        led_segments    = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        reset           = 1'b1;
        led_segments    = 8'h00;
        led_enable_mask = 6'h00;
        repeat (4) @(negedge clk);
        chk("rst_data",  32'(frame_data), 32'd0);
        chk("rst_mask",  32'(frame_present_mask), 32'd0);
        chk("rst_err",   32'(frame_decode_error), 32'd0);
        chk("rst_valid", 32'(frame_valid), 32'd0);
        reset = 1'b0;

        // Full scan 1..6 then wrap to digit 0
        show(0, P1, 1'b0, 40); show(1, P2, 1'b0, 40); show(2, P3, 1'b0, 40);
        show(3, P4, 1'b0, 40); show(4, P5, 1'b0, 40); show(5, P6, 1'b0, 40);
        push(24'h654321, 6'h3F, 1'b0);
        show(0, P1, 1'b0, 40);
        wait_drain("t1_drain");
        chk("t1_hold_data", 32'(frame_data), 32'h654321);

        // Short glitch strobe on digit 2 must not be captured
        do_reset();
        show(0, P1, 1'b0, 40); show(1, P2, 1'b0, 40);
        show(2, P3, 1'b0, 3);
        show(3, P4, 1'b0, 40);
        push(24'h004021, 6'h0B, 1'b0);
        show(0, P1, 1'b0, 40);
        wait_drain("t2_drain");

        // Digits 4,5 blanked, repeated scans
        do_reset();
        show(0, P7, 1'b0, 40); show(1, P8, 1'b0, 40); show(2, P9, 1'b0, 40); show(3, P0, 1'b0, 40);
        repeat (3) begin
            push(24'h000987, 6'h0F, 1'b0);
            show(0, P7, 1'b0, 40); show(1, P8, 1'b0, 40); show(2, P9, 1'b0, 40); show(3, P0, 1'b0, 40);
        end
        wait_drain("t3_drain");

        // Bad glyph on digit 2, then a clean frame clears the error
        do_reset();
        show(0, P1, 1'b0, 40); show(1, P2, 1'b0, 40); show(2, PBAD, 1'b0, 40);
        show(3, P4, 1'b0, 40); show(4, P5, 1'b0, 40); show(5, P6, 1'b0, 40);
        push(24'h654F21, 6'h3F, 1'b1);
        show(0, P1, 1'b0, 40);
        show(1, P2, 1'b0, 40); show(2, P3, 1'b0, 40);
        show(3, P4, 1'b0, 40); show(4, P5, 1'b0, 40); show(5, P6, 1'b0, 40);
        push(24'h654321, 6'h3F, 1'b0);
        show(0, P1, 1'b0, 40);
        wait_drain("t4_drain");

        // Partial frame published by timeout, then no more pulses
        do_reset();
        show(0, P5, 1'b0, 40); show(1, P6, 1'b0, 40);
        push(24'h000065, 6'h03, 1'b0);
        idle(TIMEOUT + 200);
        wait_drain("t5_drain");
        snap = pulses;
        idle(2000);
        chk("t5_no_extra_pulse", 32'(pulses - snap), 32'd0);
        chk("t5_hold_mask", 32'(frame_present_mask), 32'h03);

        // Reset mid-frame, dp toggling
        do_reset();
        show(0, P1, 1'b0, 40); show(1, P2, 1'b0, 40); show(2, P3, 1'b0, 40);
        push(24'h000321, 6'h07, 1'b0);
        show(0, P1, 1'b0, 40); show(1, P2, 1'b0, 40); show(2, P3, 1'b0, 40);
        wait_drain("t6_pre_drain");
        do_reset();
        chk("t6_rst_data",  32'(frame_data), 32'd0);
        chk("t6_rst_mask",  32'(frame_present_mask), 32'd0);
        chk("t6_rst_err",   32'(frame_decode_error), 32'd0);
        chk("t6_rst_valid", 32'(frame_valid), 32'd0);
        show(3, P4, 1'b0, 40); show(3, P4, 1'b1, 40);
        show(4, P5, 1'b1, 40); show(5, P6, 1'b0, 40);
        push(24'h654000, 6'h38, 1'b0);
        show(0, P7, 1'b0, 40);
        wait_drain("t6_drain");
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
